inst_fetch_unit: RTL and testbench

- Produces the 32-bit instruction stream that the decode stage consumes, one word per valid/ready handshake, together with its PC.
- Issues sequential word fetches to instruction memory over a request/response interface and buffers the returned words in a small FIFO.
- Handles redirects from branch/JAL/JALR resolution: it flushes buffered and in-flight words and restarts fetch at the new PC.

---
 rtl/rv_core_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/inst_fetch_unit.sv | 100 ++++++++++
 tb/tb_inst_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared core definitions: architectural width, reset PC, canonical NOP and the
// base opcode map used by both fetch and decode.
package rv_core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer with flush; push and pop may occur in
// the same cycle, even when full.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count define what is
  // valid, so resetting the data would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetch with credit-limited memory requests, a small
// word buffer toward decode, and redirect flush of buffered/in-flight words.
module inst_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] head_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] fifo_head;
  logic [XLEN-1:0] redirect_target;
  logic            fifo_empty;
  logic            fifo_full;
  logic            req_fire;
  logic            resp_fire;
  logic            push;
  logic            pop;

  // Words in flight plus words buffered never exceed the buffer size.
  assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = (state == FETCH_RUN) && !fifo_full &&
                          (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire        = imem_req_valid && imem_req_ready;
  assign resp_fire       = imem_resp_valid;
  assign inflight_next   = inflight + CW'(req_fire) - CW'(resp_fire);
  assign redirect_target = word_align(redirect_pc);

  assign push = resp_fire && (drop == '0) && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? '0 : fifo_head;
  assign inst_pc    = head_pc;

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (imem_resp_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH_BOOT;
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      if (state == FETCH_BOOT) state <= FETCH_RUN;
      inflight <= inflight_next;
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        fetch_pc <= redirect_target;
        head_pc  <= redirect_target;
        drop     <= inflight_next;
      end else begin
        if (req_fire)                  fetch_pc <= fetch_pc + 32'd4;
        if (pop)                       head_pc  <= head_pc + 32'd4;
        if (resp_fire && drop != '0)   drop     <= drop - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit: a queued memory model feeds
// responses, and a program-order PC model predicts every word decode accepts.
module tb_inst_fetch_unit;
  import rv_core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h @%0t", name, act, exp, $time);
    end
  endtask

  // Unique contents per address, so a stale word is always distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ INST_NOP;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc       = 0;
  int          lat_min   = 0;
  int          lat_max   = 0;
  int          ready_pct = 100;
  int          acc_cnt   = 0;
  logic        s_acc     = 1'b0;
  logic        s_resp    = 1'b0;
  logic [31:0] s_addr    = '0;

  always @(negedge clk) begin
    s_acc  = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_resp = imem_resp_valid;
    if (!rst && imem_resp_valid)
      assert (dut.inflight != '0) else $error("protocol: response with nothing in flight");
  end

  initial begin
    int    d;
    mreq_t r;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        imem_resp_valid = 1'b0;
      end else begin
        cyc++;
        if (s_resp && mq.size() > 0) void'(mq.pop_front());
        if (s_acc) begin
          d = cyc + int'($urandom_range(lat_max, lat_min));
          if (mq.size() > 0 && d < mq[mq.size()-1].due) d = mq[mq.size()-1].due;
          r.addr = s_addr;
          r.due  = d;
          mq.push_back(r);
          acc_cnt++;
        end
        #1;
        imem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mq[0].addr);
        end else begin
          imem_resp_valid = 1'b0;
          imem_resp_data  = '0;
        end
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model_pc  = RST_PC;
  int          pop_cnt   = 0;
  logic [31:0] last_pc   = '0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_inst = '0;
  logic [31:0] hold_pc   = '0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        model_pc  = RST_PC;
        hold_prev = 1'b0;
      end else begin
        if (imem_req_valid) check("req_align", {30'b0, imem_req_addr[1:0]}, 32'h0);
        if (hold_prev && inst_valid) begin
          check("hold_inst", inst, hold_inst);
          check("hold_pc", inst_pc, hold_pc);
        end
        hold_prev = inst_valid && !inst_ready && !redirect_valid;
        hold_inst = inst;
        hold_pc   = inst_pc;
        if (inst_valid && inst_ready) begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_word", inst, mem_word(e));
          pop_cnt++;
          last_pc = inst_pc;
        end
        if (redirect_valid) begin
          exp_q.delete();
          model_pc = {redirect_pc[31:2], 2'b00};
        end
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(model_pc);
        model_pc += 32'd4;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    int start;
    int n;
    start = pop_cnt;
    n     = 0;
    while (pop_cnt == start && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (pop_cnt == start) check({name, "_timeout"}, 32'd0, 32'd1);
    else                  check(name, last_pc, exp_pc);
  endtask

  task automatic wait_cond_timeout(input string name);
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int a0;
    int p0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, RST_PC);
    check("rst_req_addr", imem_req_addr, RST_PC);

    // Boot: one idle cycle, then first request at RESET_PC
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); check("boot_no_req", imem_req_valid, 0);
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, RST_PC);
    wait_pop("seq0", 32'h0);
    wait_pop("seq1", 32'h4);
    wait_pop("seq2", 32'h8);

    // Backpressure: credit caps requests at DEPTH
    inst_ready = 1'b0;
    do_reset();
    a0 = acc_cnt;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("bp_req_count", acc_cnt - a0, DEPTH);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_inst_valid", inst_valid, 1);
    check("bp_inst_pc", inst_pc, RST_PC);
    check("bp_inst", inst, mem_word(RST_PC));
    @(posedge clk); #2 inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); check("bp_resume", imem_req_valid, 1);

    // Redirect with two requests in flight
    lat_min = 4; lat_max = 4;
    do_reset();
    n = 0;
    while (!(mq.size() == 2 && !inst_valid) && n < 50) begin @(posedge clk); #2; n++; end
    if (n == 50) wait_cond_timeout("rd_inflight");
    pulse_redirect(32'h100);
    lat_min = 0; lat_max = 0;
    check("rd_inst_valid", inst_valid, 0);
    check("rd_req_addr", imem_req_addr, 32'h100);
    wait_pop("rd_first_pc", 32'h100);

    // Redirect coinciding with a response; low bits of target ignored
    n = 0;
    while (!imem_resp_valid && n < 50) begin @(posedge clk); #2; n++; end
    if (n == 50) wait_cond_timeout("rd_resp");
    pulse_redirect(32'h203);
    check("rdr_inst_valid", inst_valid, 0);
    check("rdr_req_addr", imem_req_addr, 32'h200);
    wait_pop("rdr_first_pc", 32'h200);

    // Redirect coinciding with the decode handshake of pc 0x10
    do_reset();
    n = 0;
    while (!(inst_valid && inst_pc == 32'h10) && n < 100) begin @(posedge clk); #2; n++; end
    if (n == 100) wait_cond_timeout("rdh_pc10");
    p0 = pop_cnt;
    pulse_redirect(32'h80);
    check("rdh_consumed", pop_cnt - p0, 1);
    check("rdh_last", last_pc, 32'h10);
    wait_pop("rdh_next_pc", 32'h80);

    // Reset mid-stream with the buffer full
    inst_ready = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("mid_full", inst_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_inst_valid", inst_valid, 0);
    check("mid_req_valid", imem_req_valid, 0);
    check("mid_req_addr", imem_req_addr, RST_PC);
    check("mid_inst_pc", inst_pc, RST_PC);
    @(posedge clk); #2 rst = 1'b0;
    inst_ready = 1'b1;
    wait_pop("mid_restart_pc", RST_PC);

    // Randomized traffic
    lat_min = 0; lat_max = 3; ready_pct = 70;
    do_reset();
    p0 = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(39, 0) == 0) pulse_redirect($urandom);
    end
    inst_ready = 1'b1;
    ready_pct  = 100;
    repeat (20) @(posedge clk);
    check("rand_progress", (pop_cnt - p0) > 500, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
